// File: rtl/wired_lsu_iq.sv
// In-order load/store issue queue in front of the LSU request port.
// Captures operands from writeback wakeups and issues the oldest entry with computed vaddr/strb/wdata.
module wired_lsu_iq #(
    parameter int DEPTH = 8,
    parameter int RID_W = 6,
    parameter int WK_N  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush_i,
    input  logic                  disp_valid_i,
    output logic                  disp_ready_o,
    input  logic                  disp_store_i,
    input  logic [2:0]            disp_cacop_i,
    input  logic                  disp_dbar_i,
    input  logic                  disp_llsc_i,
    input  logic [1:0]            disp_msize_i,
    input  logic [31:0]           disp_imm_i,
    input  logic                  disp_rj_rdy_i,
    input  logic                  disp_rk_rdy_i,
    input  logic [RID_W-1:0]      disp_rj_rid_i,
    input  logic [RID_W-1:0]      disp_rk_rid_i,
    input  logic [31:0]           disp_rj_data_i,
    input  logic [31:0]           disp_rk_data_i,
    input  logic [WK_N-1:0]       wk_valid_i,
    input  logic [WK_N*RID_W-1:0] wk_rid_i,
    input  logic [WK_N*32-1:0]    wk_data_i,
    output logic                  lsu_req_valid_o,
    input  logic                  lsu_req_ready_i,
    output logic [31:0]           lsu_req_vaddr_o,
    output logic [31:0]           lsu_req_wdata_o,
    output logic [3:0]            lsu_req_strb_o,
    output logic [2:0]            lsu_req_cacop_o,
    output logic                  lsu_req_dbar_o,
    output logic                  lsu_req_llsc_o,
    output logic [1:0]            lsu_req_msize_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      head, tail;
    logic [PW-1:0]    head_idx, tail_idx;
    logic             full, disp_fire, issue_fire;

    logic [DEPTH-1:0] ent_valid, ent_store, ent_dbar, ent_llsc, ent_rj_rdy, ent_rk_rdy;
    logic [2:0]       ent_cacop   [DEPTH];
    logic [1:0]       ent_msize   [DEPTH];
    logic [31:0]      ent_imm     [DEPTH];
    logic [RID_W-1:0] ent_rj_rid  [DEPTH];
    logic [RID_W-1:0] ent_rk_rid  [DEPTH];
    logic [31:0]      ent_rj_data [DEPTH];
    logic [31:0]      ent_rk_data [DEPTH];

    // {hit, data}; scanning downward lets the lowest matching port win.
    logic [32:0] rj_wk [DEPTH];
    logic [32:0] rk_wk [DEPTH];
    logic [32:0] disp_rj_wk, disp_rk_wk;

    function automatic logic [32:0] wk_lookup(input logic [RID_W-1:0] rid);
        logic [32:0] res;
        res = '0;
        for (int p = WK_N - 1; p >= 0; p--) begin
            if (wk_valid_i[p] && wk_rid_i[p*RID_W +: RID_W] == rid)
                res = {1'b1, wk_data_i[p*32 +: 32]};
        end
        return res;
    endfunction

    assign head_idx     = head[PW-1:0];
    assign tail_idx     = tail[PW-1:0];
    assign full         = (head_idx == tail_idx) && (head[PW] != tail[PW]);
    assign disp_ready_o = !full;
    assign disp_fire    = disp_valid_i && disp_ready_o && !flush_i;
    assign issue_fire   = lsu_req_valid_o && lsu_req_ready_i;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rj_wk[i] = wk_lookup(ent_rj_rid[i]);
            rk_wk[i] = wk_lookup(ent_rk_rid[i]);
        end
        disp_rj_wk = wk_lookup(disp_rj_rid_i);
        disp_rk_wk = wk_lookup(disp_rk_rid_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
        end else if (flush_i) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
        end else begin
            if (disp_fire) begin
                tail                <= tail + (PW+1)'(1);
                ent_valid[tail_idx] <= 1'b1;
            end
            if (issue_fire) begin
                head                <= head + (PW+1)'(1);
                ent_valid[head_idx] <= 1'b0;
            end
        end
    end

    // NOTE: payload storage is deliberately left out of reset; ent_valid alone qualifies it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && !ent_rj_rdy[i] && rj_wk[i][32]) begin
                ent_rj_rdy[i]  <= 1'b1;
                ent_rj_data[i] <= rj_wk[i][31:0];
            end
            if (ent_valid[i] && !ent_rk_rdy[i] && rk_wk[i][32]) begin
                ent_rk_rdy[i]  <= 1'b1;
                ent_rk_data[i] <= rk_wk[i][31:0];
            end
        end
        if (disp_fire) begin
            ent_store[tail_idx]   <= disp_store_i;
            ent_cacop[tail_idx]   <= disp_cacop_i;
            ent_dbar[tail_idx]    <= disp_dbar_i;
            ent_llsc[tail_idx]    <= disp_llsc_i;
            ent_msize[tail_idx]   <= disp_msize_i;
            ent_imm[tail_idx]     <= disp_imm_i;
            ent_rj_rid[tail_idx]  <= disp_rj_rid_i;
            ent_rk_rid[tail_idx]  <= disp_rk_rid_i;
            ent_rj_rdy[tail_idx]  <= disp_rj_rdy_i || disp_rj_wk[32];
            ent_rk_rdy[tail_idx]  <= disp_rk_rdy_i || disp_rk_wk[32];
            ent_rj_data[tail_idx] <= disp_rj_rdy_i ? disp_rj_data_i : disp_rj_wk[31:0];
            ent_rk_data[tail_idx] <= disp_rk_rdy_i ? disp_rk_data_i : disp_rk_wk[31:0];
        end
    end

    always_comb begin
        lsu_req_valid_o = ent_valid[head_idx] && ent_rj_rdy[head_idx] &&
                          ent_rk_rdy[head_idx] && !flush_i;
        lsu_req_vaddr_o = ent_rj_data[head_idx] + ent_imm[head_idx];
        lsu_req_cacop_o = ent_cacop[head_idx];
        lsu_req_dbar_o  = ent_dbar[head_idx];
        lsu_req_llsc_o  = ent_llsc[head_idx];
        lsu_req_msize_o = ent_msize[head_idx];
        lsu_req_strb_o  = 4'b0000;
        lsu_req_wdata_o = ent_rk_data[head_idx];
        case (ent_msize[head_idx])
            2'd0: begin
                lsu_req_strb_o  = 4'b0001 << lsu_req_vaddr_o[1:0];
                lsu_req_wdata_o = {4{ent_rk_data[head_idx][7:0]}};
            end
            2'd1: begin
                lsu_req_strb_o  = 4'b0011 << {lsu_req_vaddr_o[1], 1'b0};
                lsu_req_wdata_o = {2{ent_rk_data[head_idx][15:0]}};
            end
            default: lsu_req_strb_o = 4'b1111;
        endcase
        if (!ent_store[head_idx])
            lsu_req_strb_o = 4'b0000;
    end
endmodule

// File: tb/tb_wired_lsu_iq.sv
// Scoreboard bench for wired_lsu_iq: directed dispatches push expected requests,
// a monitor pops and compares on every accepted LSU request.
module tb_wired_lsu_iq;
    localparam int DEPTH = 8;
    localparam int RID_W = 6;
    localparam int WK_N  = 2;

    typedef struct {
        logic [31:0] vaddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  cacop;
        logic        dbar;
        logic        llsc;
        logic [1:0]  msize;
        logic        store;
    } exp_t;

    logic                  clk = 0;
    logic                  rst_n = 0;
    logic                  flush_i = 0;
    logic                  disp_valid_i = 0;
    logic                  disp_ready_o;
    logic                  disp_store_i = 0;
    logic [2:0]            disp_cacop_i = 0;
    logic                  disp_dbar_i = 0;
    logic                  disp_llsc_i = 0;
    logic [1:0]            disp_msize_i = 0;
    logic [31:0]           disp_imm_i = 0;
    logic                  disp_rj_rdy_i = 0, disp_rk_rdy_i = 0;
    logic [RID_W-1:0]      disp_rj_rid_i = 0, disp_rk_rid_i = 0;
    logic [31:0]           disp_rj_data_i = 0, disp_rk_data_i = 0;
    logic [WK_N-1:0]       wk_valid_i = 0;
    logic [WK_N*RID_W-1:0] wk_rid_i = 0;
    logic [WK_N*32-1:0]    wk_data_i = 0;
    logic                  lsu_req_valid_o;
    logic                  lsu_req_ready_i = 0;
    logic [31:0]           lsu_req_vaddr_o, lsu_req_wdata_o;
    logic [3:0]            lsu_req_strb_o;
    logic [2:0]            lsu_req_cacop_o;
    logic                  lsu_req_dbar_o, lsu_req_llsc_o;
    logic [1:0]            lsu_req_msize_o;

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    logic        hold = 0, hold_flush = 0;
    logic [31:0] hold_vaddr, hold_wdata;
    logic [3:0]  hold_strb;

    wired_lsu_iq #(.DEPTH(DEPTH), .RID_W(RID_W), .WK_N(WK_N)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_store_i(disp_store_i), .disp_cacop_i(disp_cacop_i),
        .disp_dbar_i(disp_dbar_i), .disp_llsc_i(disp_llsc_i),
        .disp_msize_i(disp_msize_i), .disp_imm_i(disp_imm_i),
        .disp_rj_rdy_i(disp_rj_rdy_i), .disp_rk_rdy_i(disp_rk_rdy_i),
        .disp_rj_rid_i(disp_rj_rid_i), .disp_rk_rid_i(disp_rk_rid_i),
        .disp_rj_data_i(disp_rj_data_i), .disp_rk_data_i(disp_rk_data_i),
        .wk_valid_i(wk_valid_i), .wk_rid_i(wk_rid_i), .wk_data_i(wk_data_i),
        .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_ready_i(lsu_req_ready_i),
        .lsu_req_vaddr_o(lsu_req_vaddr_o), .lsu_req_wdata_o(lsu_req_wdata_o),
        .lsu_req_strb_o(lsu_req_strb_o), .lsu_req_cacop_o(lsu_req_cacop_o),
        .lsu_req_dbar_o(lsu_req_dbar_o), .lsu_req_llsc_o(lsu_req_llsc_o),
        .lsu_req_msize_o(lsu_req_msize_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one dispatch, waits (bounded) for acceptance, and records the expected request.
    task automatic disp_op(input logic store, input logic [1:0] msize, input logic [31:0] imm,
                           input logic rj_rdy, input logic [RID_W-1:0] rj_rid, input logic [31:0] rj_data,
                           input logic rk_rdy, input logic [RID_W-1:0] rk_rid, input logic [31:0] rk_data,
                           input logic [31:0] e_vaddr, input logic [31:0] e_wdata, input logic [3:0] e_strb,
                           input logic [2:0] cacop, input logic dbar, input logic llsc);
        exp_t e;
        int   n;
        disp_store_i = store;   disp_msize_i = msize;   disp_imm_i = imm;
        disp_rj_rdy_i = rj_rdy; disp_rj_rid_i = rj_rid; disp_rj_data_i = rj_data;
        disp_rk_rdy_i = rk_rdy; disp_rk_rid_i = rk_rid; disp_rk_data_i = rk_data;
        disp_cacop_i = cacop;   disp_dbar_i = dbar;     disp_llsc_i = llsc;
        disp_valid_i = 1'b1;
        n = 0;
        @(negedge clk);
        while (!disp_ready_o && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!disp_ready_o) begin
            check("disp_ready_timeout", {31'd0, disp_ready_o}, 32'd1);
            disp_valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        e = '{vaddr: e_vaddr, wdata: e_wdata, strb: e_strb, cacop: cacop,
              dbar: dbar, llsc: llsc, msize: msize, store: store};
        exp_q.push_back(e);
        #1;
        disp_valid_i = 1'b0;
    endtask

    always @(negedge rst_n) hold = 1'b0;

    // Monitor: compares every accepted request and checks valid/output stability while stalled.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (hold && !hold_flush && !flush_i) begin
                check("hold_valid", {31'd0, lsu_req_valid_o}, 32'd1);
                check("hold_vaddr", lsu_req_vaddr_o, hold_vaddr);
                check("hold_strb", {28'd0, lsu_req_strb_o}, {28'd0, hold_strb});
                check("hold_wdata", lsu_req_wdata_o, hold_wdata);
            end
            if (lsu_req_valid_o && lsu_req_ready_i) begin
                check("issue_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("vaddr", lsu_req_vaddr_o, e.vaddr);
                    check("strb", {28'd0, lsu_req_strb_o}, {28'd0, e.strb});
                    if (e.store) check("wdata", lsu_req_wdata_o, e.wdata);
                    check("cacop", {29'd0, lsu_req_cacop_o}, {29'd0, e.cacop});
                    check("dbar_llsc_msize", {28'd0, lsu_req_dbar_o, lsu_req_llsc_o, lsu_req_msize_o},
                          {28'd0, e.dbar, e.llsc, e.msize});
                end
            end
            hold       = lsu_req_valid_o && !lsu_req_ready_i;
            hold_flush = flush_i;
            hold_vaddr = lsu_req_vaddr_o;
            hold_wdata = lsu_req_wdata_o;
            hold_strb  = lsu_req_strb_o;
        end
    end

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, lsu_req_valid_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_disp_ready", {31'd0, disp_ready_o}, 32'd1);
        check("reset_empty", {31'd0, lsu_req_valid_o}, 32'd0);
        step();

        // ld.w with 1-cycle latency, then empty
        lsu_req_ready_i = 1'b1;
        disp_op(0, 2'd2, 32'h10, 1, 0, 32'h1000, 1, 0, 32'h0, 32'h1010, 32'h0, 4'b0000, 3'd0, 0, 0);
        @(negedge clk);
        check("ld_latency_valid", {31'd0, lsu_req_valid_o}, 32'd1);
        step();
        @(negedge clk);
        check("ld_empty_after", {31'd0, lsu_req_valid_o}, 32'd0);
        step();

        // store alignment and pass-through fields
        disp_op(1, 2'd0, 32'h0, 1, 0, 32'h2003, 1, 0, 32'h000000AB, 32'h2003, 32'hABABABAB, 4'b1000, 3'd0, 0, 0);
        disp_op(1, 2'd1, 32'h0, 1, 0, 32'h3002, 1, 0, 32'h12345678, 32'h3002, 32'h56785678, 4'b1100, 3'd0, 0, 0);
        disp_op(1, 2'd2, 32'hFFFFFFFC, 1, 0, 32'h4000, 1, 0, 32'hDEADBEEF, 32'h3FFC, 32'hDEADBEEF, 4'b1111, 3'd0, 0, 0);
        disp_op(0, 2'd1, 32'hFFFFFFF0, 1, 0, 32'h10, 1, 0, 32'h0, 32'h0, 32'h0, 4'b0000, 3'd5, 1, 1);
        drain("drain_stores");
        step();

        // wakeup on port 1, two cycles after dispatch
        disp_op(0, 2'd2, 32'h8, 0, 6'd5, 32'h0, 1, 0, 32'h0, 32'h48, 32'h0, 4'b0000, 3'd0, 0, 0);
        @(negedge clk);
        check("wait_operand_0", {31'd0, lsu_req_valid_o}, 32'd0);
        step();
        wk_valid_i = 2'b10;
        wk_rid_i   = {6'd5, 6'd0};
        wk_data_i  = {32'h40, 32'h0};
        @(negedge clk);
        check("wait_operand_1", {31'd0, lsu_req_valid_o}, 32'd0);
        step();
        wk_valid_i = 2'b00;
        @(negedge clk);
        check("wake_valid", {31'd0, lsu_req_valid_o}, 32'd1);
        step();

        // both ports match: port 0 wins
        disp_op(1, 2'd2, 32'h0, 1, 0, 32'h6000, 0, 6'd9, 32'h0, 32'h6000, 32'h11111111, 4'b1111, 3'd0, 0, 0);
        wk_valid_i = 2'b11;
        wk_rid_i   = {6'd9, 6'd9};
        wk_data_i  = {32'h22222222, 32'h11111111};
        step();
        wk_valid_i = 2'b00;
        drain("drain_lowest_port");
        step();

        // wakeup in the dispatch cycle
        wk_valid_i = 2'b01;
        wk_rid_i   = {6'd0, 6'd7};
        wk_data_i  = {32'h0, 32'h500};
        disp_op(0, 2'd2, 32'h4, 0, 6'd7, 32'h0, 1, 0, 32'h0, 32'h504, 32'h0, 4'b0000, 3'd0, 0, 0);
        wk_valid_i = 2'b00;
        @(negedge clk);
        check("same_cycle_wake", {31'd0, lsu_req_valid_o}, 32'd1);
        step();

        // fill, then drain while refilling across the pointer wrap
        lsu_req_ready_i = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            disp_op(0, 2'd2, 32'h4, 1, 0, i * 32'h100, 1, 0, 32'h0, i * 32'h100 + 32'h4, 32'h0, 4'b0000, 3'd0, 0, 0);
        @(negedge clk);
        check("full_disp_ready", {31'd0, disp_ready_o}, 32'd0);
        check("full_valid", {31'd0, lsu_req_valid_o}, 32'd1);
        step();
        lsu_req_ready_i = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            disp_op(1, 2'd0, 32'h0, 1, 0, 32'h8000 + i, 1, 0, 32'h000000C0 + i,
                    32'h8000 + i, {4{8'hC0 + 8'(i)}}, 4'b0001 << (i % 4), 3'd0, 0, 0);
        drain("drain_wrap");
        step();

        // flush with 3 queued entries, concurrent dispatch and ready
        lsu_req_ready_i = 1'b0;
        for (int i = 0; i < 3; i++)
            disp_op(0, 2'd2, 32'h0, 1, 0, 32'hA000 + i * 4, 1, 0, 32'h0, 32'hA000 + i * 4, 32'h0, 4'b0000, 3'd0, 0, 0);
        flush_i         = 1'b1;
        disp_valid_i    = 1'b1;
        disp_rj_data_i  = 32'hBAD0;
        lsu_req_ready_i = 1'b1;
        @(negedge clk);
        check("flush_blocks_issue", {31'd0, lsu_req_valid_o}, 32'd0);
        step();
        flush_i      = 1'b0;
        disp_valid_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_empty_valid", {31'd0, lsu_req_valid_o}, 32'd0);
        check("flush_disp_ready", {31'd0, disp_ready_o}, 32'd1);
        step();
        disp_op(0, 2'd2, 32'h70, 1, 0, 32'h7700, 1, 0, 32'h0, 32'h7770, 32'h0, 4'b0000, 3'd0, 0, 0);
        drain("drain_after_flush");
        step();

        // asynchronous reset mid-stream
        lsu_req_ready_i = 1'b0;
        disp_op(0, 2'd2, 32'h0, 1, 0, 32'hB000, 1, 0, 32'h0, 32'hB000, 32'h0, 4'b0000, 3'd0, 0, 0);
        disp_op(0, 2'd2, 32'h0, 1, 0, 32'hB004, 1, 0, 32'h0, 32'hB004, 32'h0, 4'b0000, 3'd0, 0, 0);
        @(negedge clk);
        check("pre_reset_valid", {31'd0, lsu_req_valid_o}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_drops_valid", {31'd0, lsu_req_valid_o}, 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_disp_ready", {31'd0, disp_ready_o}, 32'd1);
        check("post_reset_empty", {31'd0, lsu_req_valid_o}, 32'd0);
        step();
        lsu_req_ready_i = 1'b1;
        disp_op(1, 2'd1, 32'h1, 1, 0, 32'hC000, 1, 0, 32'h0000BEEF, 32'hC001, 32'hBEEFBEEF, 4'b0011, 3'd0, 0, 0);
        drain("drain_after_reset");

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
